// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: MDU states, stage ids, vectors.
// Used by the hazard controller and stage registers.
package pipe_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2
  } mdu_state_e;

  typedef enum logic [2:0] {
    STG_F = 3'd0,
    STG_D = 3'd1,
    STG_E = 3'd2,
    STG_M = 3'd3,
    STG_W = 3'd4
  } stage_e;

  localparam logic [1:0]  TUSE_NONE  = 2'd3;
  localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;
  localparam logic [31:0] RESET_PC   = 32'h0000_3000;

  // Source register still waiting on a younger producer.
  function automatic logic hz_match(
    input logic [4:0] src,
    input logic [4:0] wa,
    input logic [1:0] tuse,
    input logic [1:0] tnew
  );
    return (src != 5'd0) && (src == wa) &&
           (tuse != TUSE_NONE) && (tuse < tnew);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard controller bus: pipeline status in, stage controls out.
// master = pipeline side, slave = controller side.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 4
);
  logic [4:0]       d_rs;
  logic [4:0]       d_rt;
  logic [1:0]       d_tuse_rs;
  logic [1:0]       d_tuse_rt;
  logic             d_is_mdu;
  logic [4:0]       e_wa;
  logic [4:0]       m_wa;
  logic [1:0]       e_tnew;
  logic [1:0]       m_tnew;
  logic             e_mdu_start;
  logic             e_mdu_div;
  logic             exc_req;
  logic             f_en;
  logic             d_en;
  logic             e_en;
  logic             m_en;
  logic             e_clr;
  logic             req;
  logic             mdu_busy;
  logic [CNT_W-1:0] mdu_cnt;

  modport master (
    output d_rs, d_rt, d_tuse_rs, d_tuse_rt,
    output d_is_mdu, e_wa, m_wa, e_tnew, m_tnew,
    output e_mdu_start, e_mdu_div, exc_req,
    input  f_en, d_en, e_en, m_en, e_clr, req,
    input  mdu_busy, mdu_cnt
  );

  modport slave (
    input  d_rs, d_rt, d_tuse_rs, d_tuse_rt,
    input  d_is_mdu, e_wa, m_wa, e_tnew, m_tnew,
    input  e_mdu_start, e_mdu_div, exc_req,
    output f_en, d_en, e_en, m_en, e_clr, req,
    output mdu_busy, mdu_cnt
  );
endinterface

// File: rtl/mdu_busy_fsm.sv
// MDU busy sequencer: IDLE/MULT/DIV with a countdown.
// Busy and count are registered; clr abandons any operation.
module mdu_busy_fsm
  import pipe_pkg::*;
#(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start_i,
  input  logic             div_i,
  input  logic             exc_i,
  output logic             busy_o,
  output logic [CNT_W-1:0] cnt_o
);

  mdu_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;

  // Start only from IDLE and only if the starter is not flushed.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i && !exc_i) begin
            busy_q <= 1'b1;
            if (div_i) begin
              state_q <= DIV;
              cnt_q   <= CNT_W'(DIV_CYC);
            end else begin
              state_q <= MULT;
              cnt_q   <= CNT_W'(MULT_CYC);
            end
          end
        end
        MULT, DIV: begin
          if (cnt_q == CNT_W'(1)) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o = busy_q;
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the F/D/E/M/W pipeline.
// Optional stall counters: define HAZARD_STALL_CNT_EN.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10,
  parameter int CNT_W    = 4
) (
  input  logic                clk,
  input  logic                clr,
  pipe_hazard_ctrl_if.slave   bus
`ifdef HAZARD_STALL_CNT_EN
  ,
  output logic [31:0]         stall_cycles,
  output logic [31:0]         mdu_stall_cycles
`endif
);

  logic stall_rs;
  logic stall_rt;
  logic stall_mdu;
  logic stall;
  logic mdu_busy;

  mdu_busy_fsm #(
    .MULT_CYC (MULT_CYC),
    .DIV_CYC  (DIV_CYC),
    .CNT_W    (CNT_W)
  ) u_mdu (
    .clk     (clk),
    .clr     (clr),
    .start_i (bus.e_mdu_start),
    .div_i   (bus.e_mdu_div),
    .exc_i   (bus.exc_req),
    .busy_o  (mdu_busy),
    .cnt_o   (bus.mdu_cnt)
  );

  assign bus.mdu_busy = mdu_busy;

  // Tuse/Tnew checks against E and M producers.
  always_comb begin
    stall_rs =
      hz_match(bus.d_rs, bus.e_wa,
               bus.d_tuse_rs, bus.e_tnew) |
      hz_match(bus.d_rs, bus.m_wa,
               bus.d_tuse_rs, bus.m_tnew);
    stall_rt =
      hz_match(bus.d_rt, bus.e_wa,
               bus.d_tuse_rt, bus.e_tnew) |
      hz_match(bus.d_rt, bus.m_wa,
               bus.d_tuse_rt, bus.m_tnew);
    stall_mdu = bus.d_is_mdu &
                (mdu_busy | bus.e_mdu_start);
    stall = stall_rs | stall_rt | stall_mdu;
  end

  // Stage controls; an exception flush beats any stall.
  always_comb begin
    bus.f_en  = ~stall;
    bus.d_en  = ~stall;
    bus.e_en  = 1'b1;
    bus.m_en  = 1'b1;
    bus.e_clr = stall;
    bus.req   = 1'b0;
    if (bus.exc_req) begin
      bus.f_en  = 1'b1;
      bus.d_en  = 1'b1;
      bus.e_clr = 1'b0;
      bus.req   = 1'b1;
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] mdu_stall_cnt_q;

  // Count cycles actually lost to stalls (flush cycles excluded).
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      stall_cnt_q     <= '0;
      mdu_stall_cnt_q <= '0;
    end else begin
      if (stall && !bus.exc_req)
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (stall_mdu && !bus.exc_req)
        mdu_stall_cnt_q <= mdu_stall_cnt_q + 32'd1;
    end
  end

  assign stall_cycles     = stall_cnt_q;
  assign mdu_stall_cycles = mdu_stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed cases plus random traffic
// against a countdown-based reference model.
module tb_pipe_hazard_ctrl;

  localparam int MULT_CYC = 5;
  localparam int DIV_CYC  = 10;
  localparam int CNT_W    = 4;

  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stall_cycles;
  logic [31:0] mdu_stall_cycles;
`endif

  pipe_hazard_ctrl #(
    .MULT_CYC (MULT_CYC),
    .DIV_CYC  (DIV_CYC),
    .CNT_W    (CNT_W)
  ) dut (
    .clk  (clk),
    .clr  (clr),
    .bus  (hz.slave)
`ifdef HAZARD_STALL_CNT_EN
    ,
    .stall_cycles     (stall_cycles),
    .mdu_stall_cycles (mdu_stall_cycles)
`endif
  );

  int n_chk = 0;
  int n_err = 0;

  // model: remaining busy cycles and stall tallies
  int          m_cnt = 0;
  logic [31:0] m_stall = 0;
  logic [31:0] m_mstall = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic bit waits(input int src, input int wa,
                               input int tuse, input int tnew);
    return src != 0 && src == wa && tuse < tnew;
  endfunction

  function automatic bit exp_mstall();
    return hz.d_is_mdu && (m_cnt > 0 || hz.e_mdu_start);
  endfunction

  function automatic bit exp_stall();
    bit s;
    s = waits(hz.d_rs, hz.e_wa, hz.d_tuse_rs, hz.e_tnew) ||
        waits(hz.d_rs, hz.m_wa, hz.d_tuse_rs, hz.m_tnew) ||
        waits(hz.d_rt, hz.e_wa, hz.d_tuse_rt, hz.e_tnew) ||
        waits(hz.d_rt, hz.m_wa, hz.d_tuse_rt, hz.m_tnew);
    return s || exp_mstall();
  endfunction

  task automatic idle_inputs();
    hz.d_rs = 0; hz.d_rt = 0;
    hz.d_tuse_rs = 3; hz.d_tuse_rt = 3;
    hz.d_is_mdu = 0;
    hz.e_wa = 0; hz.m_wa = 0;
    hz.e_tnew = 0; hz.m_tnew = 0;
    hz.e_mdu_start = 0; hz.e_mdu_div = 0;
    hz.exc_req = 0;
  endtask

  // Check one cycle, then advance model across the edge.
  task automatic cycle();
    bit st;
    bit ex;
    #1;
    st = exp_stall();
    ex = hz.exc_req;
    chk("f_en",  hz.f_en,  ex ? 1 : !st);
    chk("d_en",  hz.d_en,  ex ? 1 : !st);
    chk("e_en",  hz.e_en,  1);
    chk("m_en",  hz.m_en,  1);
    chk("e_clr", hz.e_clr, ex ? 0 : st);
    chk("req",   hz.req,   ex);
    chk("busy",  hz.mdu_busy, m_cnt > 0);
    chk("cnt",   hz.mdu_cnt,  m_cnt);
`ifdef HAZARD_STALL_CNT_EN
    chk("stall_cycles", stall_cycles, m_stall);
    chk("mdu_stall_cycles", mdu_stall_cycles, m_mstall);
`endif
    @(posedge clk);
    if (st && !ex) m_stall = m_stall + 1;
    if (exp_mstall() && !ex) m_mstall = m_mstall + 1;
    if (m_cnt > 0)
      m_cnt = m_cnt - 1;
    else if (hz.e_mdu_start && !ex)
      m_cnt = hz.e_mdu_div ? DIV_CYC : MULT_CYC;
    @(negedge clk);
  endtask

  initial begin
    idle_inputs();
    #2;
    chk("rst_busy", hz.mdu_busy, 0);
    chk("rst_cnt",  hz.mdu_cnt,  0);
    chk("rst_f_en", hz.f_en, 1);
`ifdef HAZARD_STALL_CNT_EN
    chk("rst_sc", stall_cycles, 0);
    chk("rst_msc", mdu_stall_cycles, 0);
`endif
    @(negedge clk);
    clr = 1'b0;

    // load-use on rs from E
    hz.e_wa = 5; hz.e_tnew = 2;
    hz.d_rs = 5; hz.d_tuse_rs = 1;
    #1;
    chk("lu_f_en",  hz.f_en,  0);
    chk("lu_e_clr", hz.e_clr, 1);
    cycle();
    hz.e_tnew = 1;
    #1 chk("lu_ok", hz.d_en, 1);
    cycle();

    // $0 never stalls
    idle_inputs();
    hz.e_tnew = 2; hz.d_tuse_rs = 0;
    #1 chk("r0_f_en", hz.f_en, 1);
    cycle();

    // mult with an MDU user waiting in D
    idle_inputs();
    hz.d_is_mdu = 1; hz.e_mdu_start = 1;
    cycle();
    hz.e_mdu_start = 0;
    for (int i = 0; i < MULT_CYC; i++) begin
      #1 chk("mul_cnt", hz.mdu_cnt, MULT_CYC - i);
      cycle();
    end
    #1 chk("mul_done", hz.f_en, 1);
    cycle();

    // div, flush hits on the third busy cycle
    idle_inputs();
    hz.e_mdu_start = 1; hz.e_mdu_div = 1;
    cycle();
    hz.e_mdu_start = 0; hz.d_is_mdu = 1;
    for (int i = 0; i < DIV_CYC + 1; i++) begin
      hz.exc_req = (i == 2);
      cycle();
    end
    hz.exc_req = 0;
    #1 chk("div_done", hz.mdu_busy, 0);

    // start killed by a flush
    idle_inputs();
    hz.e_mdu_start = 1; hz.exc_req = 1;
    cycle();
    idle_inputs();
    #1 chk("exc_start", hz.mdu_busy, 0);
    cycle();

    // clr mid-div at cnt=6
    hz.e_mdu_start = 1; hz.e_mdu_div = 1;
    cycle();
    hz.e_mdu_start = 0;
    for (int i = 0; i < DIV_CYC - 6; i++) cycle();
    #1 chk("pre_clr_cnt", hz.mdu_cnt, 6);
    #1 clr = 1'b1;
    #1;
    chk("clr_busy", hz.mdu_busy, 0);
    chk("clr_cnt",  hz.mdu_cnt,  0);
    m_cnt = 0; m_stall = 0; m_mstall = 0;
    @(negedge clk);
    clr = 1'b0;

`ifdef HAZARD_STALL_CNT_EN
    hz.e_wa = 5; hz.e_tnew = 2;
    hz.d_rs = 5; hz.d_tuse_rs = 1;
    cycle();
    hz.e_tnew = 1;
    cycle();
    #1 chk("cnt_lu", stall_cycles, 1);
`endif

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      hz.d_rs = 5'($urandom_range(0, 3));
      hz.d_rt = 5'($urandom_range(0, 3));
      hz.d_tuse_rs = 2'($urandom_range(0, 3));
      hz.d_tuse_rt = 2'($urandom_range(0, 3));
      hz.d_is_mdu = ($urandom_range(0, 2) == 0);
      hz.e_wa = 5'($urandom_range(0, 3));
      hz.m_wa = 5'($urandom_range(0, 3));
      hz.e_tnew = 2'($urandom_range(0, 3));
      hz.m_tnew = 2'($urandom_range(0, 3));
      hz.e_mdu_start = ($urandom_range(0, 5) == 0);
      hz.e_mdu_div = 1'($urandom_range(0, 1));
      hz.exc_req = ($urandom_range(0, 9) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage MIPS pipeline (F/D/E/M/W).
- Generates per-stage register enables and clears from Tuse/Tnew hazard checks.
- Sequences the multiply-divide unit (MDU) busy period.
- Broadcasts the exception flush request (`req`) consumed by the stage registers, which load PC 0x4180 on `req`.

Parameters:
- MULT_CYC, 5, busy cycles for mult/multu, excluding the start cycle.
- DIV_CYC, 10, busy cycles for div/divu, excluding the start cycle.
- CNT_W, 4, width of the MDU countdown; must hold max(MULT_CYC, DIV_CYC).

Ports:
- clk  in  1  clock
- clr  in  1  asynchronous active-high reset
- d_rs, d_rt  in  5  D-stage source register numbers
- d_tuse_rs, d_tuse_rt  in  2  Tuse per source; 3 = not used
- d_is_mdu  in  1  D-stage instruction uses MDU (mult/div/mfhi/mflo/mthi/mtlo)
- e_wa, m_wa  in  5  destination register in E / M; 0 = none
- e_tnew, m_tnew  in  2  remaining cycles until the result is available, in E / M
- e_mdu_start  in  1  E-stage instruction is mult/multu/div/divu
- e_mdu_div  in  1  1 = divide, 0 = multiply; valid with e_mdu_start
- exc_req  in  1  exception/interrupt taken at M (from CP0)
- f_en, d_en, e_en, m_en  out  1  stage register enables
- e_clr  out  1  insert bubble into E register
- req  out  1  flush all stage registers
- mdu_busy  out  1  registered MDU busy flag
- mdu_cnt  out  CNT_W  registered remaining busy cycles

Behaviour:
- Reset (clr=1, async):
  - state=IDLE, mdu_cnt=0, mdu_busy=0.
  - Combinational outputs therefore evaluate with no MDU stall.
- Data hazard (combinational):
  - stall_rs = d_rs≠0 & ((d_rs==e_wa & d_tuse_rs<e_tnew) | (d_rs==m_wa & d_tuse_rs<m_tnew)).
  - stall_rt is formed identically.
  - E-stage match takes priority only in the sense that either match stalls.
- MDU hazard: stall_mdu = d_is_mdu & (mdu_busy | e_mdu_start).
- stall = stall_rs | stall_rt | stall_mdu.
- Outputs, normal operation (no exc_req):
  - f_en = d_en = ~stall; e_clr = stall; e_en = m_en = 1; req = 0.
- Outputs, exc_req=1:
  - req=1; f_en = d_en = e_en = m_en = 1; e_clr = 0.
  - req overrides stall in the same cycle.
- MDU FSM states: IDLE, MULT, DIV.
  - IDLE & e_mdu_start & ~exc_req → MULT (cnt=MULT_CYC) or DIV (cnt=DIV_CYC) on the next edge.
  - MULT/DIV: cnt decrements each cycle; when cnt==1 → IDLE with cnt=0.
  - mdu_busy = (state≠IDLE).
  - Timing: a mult starting at edge 0 gives mdu_busy=1 for exactly MULT_CYC cycles.
- Simultaneous events:
  - e_mdu_start with exc_req: start is ignored because the instruction is flushed.
  - exc_req while busy: the operation continues to completion, since it is already committed; the counter is unaffected.
  - e_mdu_start while busy: cannot occur because D was stalled; if it does occur, it is ignored and the counter is not reloaded.
- clr mid-operation: FSM returns to IDLE immediately; the busy period is abandoned.

Optional Feature:
- Macro: HAZARD_STALL_CNT_EN.
- When defined:
  - Extra outputs stall_cycles [31:0] and mdu_stall_cycles [31:0].
  - Registered; 0 on clr.
  - Increment on each cycle with stall=1 & exc_req=0 (resp. stall_mdu=1 & exc_req=0).
  - Wrap at 2^32.
- When undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package pipe_pkg holds:
  - MDU state enum (IDLE, MULT, DIV).
  - TUSE_NONE = 2'd3.
  - EXC_VECTOR = 32'h4180 and RESET_PC = 32'h3000.
  - The stage enum used by stage registers.
- One sub-module: mdu_busy_fsm (FSM + countdown).
- Hazard compare logic stays inline.

Test Plan:
- Load-use: e_wa=5, e_tnew=2, d_rs=5, d_tuse_rs=1 → f_en=d_en=0, e_clr=1; with e_tnew=1 → no stall.
- Register $0: d_rs=0, e_wa=0, e_tnew=2, d_tuse_rs=0 → no stall.
- mult start with d_is_mdu held: e_mdu_start=1, e_mdu_div=0 at cycle 0 → stall in cycle 0; mdu_busy=1 for cycles 1–5, mdu_cnt 5→1; stall clears at cycle 6.
- div with exc_req at cycle 3 of busy: req=1 and all enables=1 that cycle; mdu_busy stays 1 until count completes (10 cycles).
- exc_req together with e_mdu_start → state stays IDLE, mdu_busy=0 next cycle, req=1.
- clr asserted mid-DIV (cnt=6) → mdu_busy=0 and mdu_cnt=0 immediately, without waiting for a clock edge. With HAZARD_STALL_CNT_EN defined: counters read 0 after clr, and then count the stall cycles of the first scenario exactly.
